// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types and constants for the A2D SPI conversion controller.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    GAP  = 3'd2,
    READ = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0]  CMD_PAD_HI  = 2'b00;
  localparam logic [10:0] CMD_PAD_LO  = 11'h000;
  // Puts the first SCLK fall 9 clk after SS_n falls (counter wraps 23 -> 0).
  localparam logic [4:0]  DIV_PRELOAD = 5'b10111;
  localparam int          BACK_PORCH  = 16;

  function automatic logic [15:0] mk_cmd(input logic [2:0] ch);
    return {CMD_PAD_HI, ch, CMD_PAD_LO};
  endfunction

endpackage

// File: rtl/spi_xfer16.sv
// spi_xfer16: one framed 16-bit SPI transaction, SCLK idling high.
// MOSI launches on SCLK fall, MISO is captured on SCLK rise.
module spi_xfer16
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rx_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic [1:0] {
    X_IDLE  = 2'd0,
    X_SHIFT = 2'd1,
    X_PORCH = 2'd2
  } xfer_t;

  localparam int PORCH_W = $clog2(BACK_PORCH);
  localparam logic [SCLK_DIV_W-1:0] PRELOAD  = SCLK_DIV_W'(DIV_PRELOAD);
  localparam logic [SCLK_DIV_W-1:0] DIV_FALL = {SCLK_DIV_W{1'b1}};
  localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};

  xfer_t                 r_xst;
  logic [SCLK_DIV_W-1:0] r_div;
  logic [15:0]           r_tx;
  logic [15:0]           r_rx;
  logic [3:0]            r_bit_cnt;
  logic [PORCH_W-1:0]    r_porch;
  logic                  r_ss_n;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_done;
  logic [SCLK_DIV_W-1:0] w_div_nxt;

  assign w_div_nxt = r_div + SCLK_DIV_W'(1);

  // Divider, shifters and bit/porch counters; SCLK is the registered divider MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xst     <= X_IDLE;
      r_div     <= '0;
      r_tx      <= 16'h0000;
      r_rx      <= 16'h0000;
      r_bit_cnt <= 4'd0;
      r_porch   <= '0;
      r_ss_n    <= 1'b1;
      r_sclk    <= 1'b1;
      r_mosi    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_xst)
        X_IDLE: begin
          if (wrt) begin
            r_ss_n    <= 1'b0;
            r_div     <= PRELOAD;
            r_sclk    <= PRELOAD[SCLK_DIV_W-1];
            r_tx      <= cmd;
            r_bit_cnt <= 4'd0;
            r_xst     <= X_SHIFT;
          end
        end
        X_SHIFT: begin
          r_div  <= w_div_nxt;
          r_sclk <= w_div_nxt[SCLK_DIV_W-1];
          if (r_div == DIV_FALL) begin
            r_mosi <= r_tx[15];
            r_tx   <= {r_tx[14:0], 1'b0};
          end else if (r_div == DIV_RISE) begin
            r_rx <= {r_rx[14:0], MISO};
            if (r_bit_cnt == 4'd15) begin
              r_porch <= '0;
              r_xst   <= X_PORCH;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        X_PORCH: begin
          // Divider is frozen with its MSB set, so SCLK holds high here.
          if (r_porch == PORCH_W'(BACK_PORCH - 1)) begin
            r_ss_n <= 1'b1;
            r_done <= 1'b1;
            r_xst  <= X_IDLE;
          end else begin
            r_porch <= r_porch + PORCH_W'(1);
          end
        end
        default: r_xst <= X_IDLE;
      endcase
    end
  end

  assign done    = r_done;
  assign rx_data = r_rx;
  assign SS_n    = r_ss_n;
  assign SCLK    = r_sclk;
  assign MOSI    = r_mosi;

endmodule

// File: rtl/a2d_spi_ctrl.sv
// a2d_spi_ctrl: one channel conversion per request on an ADC128S-style A2D.
// Define A2D_FAST_RPT_EN to skip the addressing transaction when the channel repeats.
module a2d_spi_ctrl
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5,
  parameter int GAP_CLKS   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  state_t           r_state;
  logic [2:0]       r_ch;
  logic             r_wrt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_cap;
  logic [11:0]      r_res;
  logic             r_cnv_cmplt;
  logic             w_done;
  logic [15:0]      w_rx;
  logic             w_rx_unused;
`ifdef A2D_FAST_RPT_EN
  logic [2:0]       r_last_ch;
  logic             r_last_vld;
`endif

  assign w_rx_unused = ^w_rx[15:12];

  spi_xfer16 #(
    .SCLK_DIV_W (SCLK_DIV_W)
  ) u_xfer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (r_wrt),
    .cmd     (mk_cmd(r_ch)),
    .done    (w_done),
    .rx_data (w_rx),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  // Conversion sequencing; res is loaded one clk ahead of the cnv_cmplt pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ch        <= 3'd0;
      r_wrt       <= 1'b0;
      r_gap_cnt   <= '0;
      r_cap       <= 1'b0;
      r_res       <= 12'h000;
      r_cnv_cmplt <= 1'b0;
`ifdef A2D_FAST_RPT_EN
      r_last_ch   <= 3'd0;
      r_last_vld  <= 1'b0;
`endif
    end else begin
      r_wrt       <= 1'b0;
      r_cnv_cmplt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (strt_cnv) begin
            r_ch  <= chnnl;
            r_wrt <= 1'b1;
`ifdef A2D_FAST_RPT_EN
            if (r_last_vld && (chnnl == r_last_ch)) begin
              r_state <= READ;
            end else begin
              r_state <= CMD;
            end
`else
            r_state <= CMD;
`endif
          end
        end
        CMD: begin
          if (w_done) begin
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_W'(GAP_CLKS - 1)) begin
            r_wrt   <= 1'b1;
            r_state <= READ;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        READ: begin
          if (r_cap) begin
            r_cap       <= 1'b0;
            r_cnv_cmplt <= 1'b1;
            r_state     <= DONE;
          end else if (w_done) begin
            r_res <= w_rx[11:0];
            r_cap <= 1'b1;
          end
        end
        DONE: begin
`ifdef A2D_FAST_RPT_EN
          r_last_ch  <= r_ch;
          r_last_vld <= 1'b1;
`endif
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cnv_cmplt = r_cnv_cmplt;
  assign res       = r_res;

endmodule

// File: tb/tb_a2d_spi_ctrl.sv
// tb_a2d_spi_ctrl: directed vector bench with a bit-level A2D slave model and SPI monitor.
module tb_a2d_spi_ctrl;

  // strt accept -> wrt (1) -> SS_n low window (521) -> done seen (1), twice,
  // plus GAP_CLKS, plus one clk for the res lead ahead of cnv_cmplt.
  localparam int LAT_FULL = 1049;
  localparam int LAT_FAST = 524;
`ifdef A2D_FAST_RPT_EN
  localparam int REP_WIN = 1;
  localparam int REP_LAT = LAT_FAST;
`else
  localparam int REP_WIN = 2;
  localparam int REP_LAT = LAT_FULL;
`endif

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] val;
    logic [15:0] exp_cmd;
    logic [11:0] exp_res;
  } vec_t;

  typedef struct {
    logic [15:0] cmd;
    int rises;
    int ff;
    int per;
    int porch;
    int gap;
  } win_t;

  logic        clk;
  logic        rst_n;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  int   checks;
  int   errors;
  int   cyc;
  int   ss_falls;
  int   cmplt_cnt;
  int   cmplt_run;
  int   cmplt_run_max;
  logic [15:0] miso_word;
  win_t wq[$];
  vec_t vecs[7];

  a2d_spi_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .res       (res),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // A2D slave model and bus monitor, sampled on the falling clk edge.
  initial begin
    logic p_ss;
    logic p_sclk;
    logic in_win;
    logic [3:0] bitidx;
    int t_fall;
    int t_lrise;
    int t_rise_ss;
    win_t cw;
    p_ss = 1'b1; p_sclk = 1'b1; in_win = 1'b0; bitidx = 4'd15;
    t_fall = 0; t_lrise = 0; t_rise_ss = 0;
    cw = '{16'h0000, 0, -1, -1, -1, -1};
    MISO = 1'b0;
    ss_falls = 0; cmplt_cnt = 0; cmplt_run = 0; cmplt_run_max = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_win = 1'b0; p_ss = 1'b1; p_sclk = 1'b1; t_rise_ss = cyc; cmplt_run = 0;
      end else begin
        if (p_ss && !SS_n) begin
          in_win = 1'b1; t_fall = cyc; bitidx = 4'd15; ss_falls++;
          cw = '{16'h0000, 0, -1, -1, -1, cyc - t_rise_ss};
        end
        if (in_win && p_sclk && !SCLK) begin
          if (cw.ff < 0) cw.ff = cyc - t_fall;
          MISO = miso_word[bitidx];
          bitidx = bitidx - 4'd1;
        end
        if (in_win && !p_sclk && SCLK) begin
          cw.rises++;
          if (cw.rises == 2) cw.per = cyc - t_lrise;
          t_lrise = cyc;
          cw.cmd = {cw.cmd[14:0], MOSI};
        end
        if (in_win && !p_ss && SS_n) begin
          cw.porch = cyc - t_lrise;
          wq.push_back(cw);
          in_win = 1'b0;
          t_rise_ss = cyc;
        end
        if (cnv_cmplt) begin
          cmplt_cnt++;
          cmplt_run++;
          if (cmplt_run > cmplt_run_max) cmplt_run_max = cmplt_run;
        end else begin
          cmplt_run = 0;
        end
        p_ss = SS_n;
        p_sclk = SCLK;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h (%0d) required=0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  function automatic win_t win_at(input int idx);
    win_t w;
    w = '{16'hDEAD, -1, -1, -1, -1, -1};
    if (idx < wq.size()) w = wq[idx];
    return w;
  endfunction

  // One request; returns res at cnv_cmplt, res one clk earlier and the latency.
  task automatic run_conv(input logic [2:0] ch, input logic [11:0] val,
                          output logic [11:0] got, output logic [11:0] lead,
                          output int lat);
    int t0;
    bit seen;
    miso_word = {4'h5, val};
    @(negedge clk);
    strt_cnv = 1'b1;
    chnnl = ch;
    t0 = cyc + 1;
    @(negedge clk);
    strt_cnv = 1'b0;
    chnnl = ~ch;
    seen = 1'b0; lat = -1; got = 12'hFFF; lead = res;
    for (int i = 0; i < 4000 && !seen; i++) begin
      if (cnv_cmplt) begin
        seen = 1'b1;
        lat = cyc - t0;
        got = res;
      end else begin
        lead = res;
        @(negedge clk);
      end
    end
    if (!seen) chk("cmplt_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [11:0] got;
    logic [11:0] lead;
    int lat;
    int nw;
    int c0;
    int f0;
    win_t w0;
    win_t w1;

    checks = 0;
    errors = 0;
    vecs[0] = '{3'd3, 12'hABC, 16'h1800, 12'hABC};
    vecs[1] = '{3'd0, 12'h000, 16'h0000, 12'h000};
    vecs[2] = '{3'd1, 12'hFFF, 16'h0800, 12'hFFF};
    vecs[3] = '{3'd2, 12'h555, 16'h1000, 12'h555};
    vecs[4] = '{3'd3, 12'hAAA, 16'h1800, 12'hAAA};
    vecs[5] = '{3'd4, 12'h123, 16'h2000, 12'h123};
    vecs[6] = '{3'd7, 12'h800, 16'h3800, 12'h800};

    rst_n = 1'b0; strt_cnv = 1'b0; chnnl = 3'd0; miso_word = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", 32'(SS_n), 32'd1);
    chk("rst_sclk", 32'(SCLK), 32'd1);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_cmplt", 32'(cnv_cmplt), 32'd0);
    chk("rst_res", 32'(res), 32'h000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      nw = wq.size();
      c0 = cmplt_cnt;
      run_conv(vecs[i].ch, vecs[i].val, got, lead, lat);
      w0 = win_at(nw);
      w1 = win_at(nw + 1);
      chk("vec_res", 32'(got), 32'(vecs[i].exp_res));
      chk("vec_res_lead", 32'(lead), 32'(vecs[i].exp_res));
      chk("vec_latency", 32'(lat), 32'(LAT_FULL));
      chk("vec_pulses", 32'(cmplt_cnt - c0), 32'd1);
      chk("vec_windows", 32'(wq.size() - nw), 32'd2);
      chk("vec_cmd_t1", 32'(w0.cmd), 32'(vecs[i].exp_cmd));
      chk("vec_cmd_t2", 32'(w1.cmd), 32'(vecs[i].exp_cmd));
      chk("vec_rises_t1", 32'(w0.rises), 32'd16);
      chk("vec_rises_t2", 32'(w1.rises), 32'd16);
      chk("vec_gap_min", 32'(w1.gap >= 4), 32'd1);
      if (i == 0) begin
        chk("tim_first_fall", 32'(w0.ff), 32'd9);
        chk("tim_period", 32'(w0.per), 32'd32);
        chk("tim_back_porch", 32'(w0.porch), 32'd16);
        chk("tim_ss_gap", 32'(w1.gap), 32'd4);
      end else begin
        chk("conv_ss_gap_min", 32'(w0.gap >= 4), 32'd1);
      end
    end

    // Busy rejection: requests during READ and during the cnv_cmplt cycle are dropped.
    nw = wq.size(); c0 = cmplt_cnt; f0 = ss_falls;
    miso_word = {4'h5, 12'h3C7};
    @(negedge clk); strt_cnv = 1'b1; chnnl = 3'd1;
    @(negedge clk); strt_cnv = 1'b0; chnnl = 3'd0;
    for (int i = 0; i < 2000 && ss_falls < f0 + 2; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    strt_cnv = 1'b1; chnnl = 3'd5;
    @(negedge clk); strt_cnv = 1'b0;
    for (int i = 0; i < 2000 && !cnv_cmplt; i++) @(negedge clk);
    strt_cnv = 1'b1; chnnl = 3'd6;
    @(negedge clk); strt_cnv = 1'b0;
    repeat (600) @(negedge clk);
    chk("busy_res", 32'(res), 32'h3C7);
    chk("busy_pulses", 32'(cmplt_cnt - c0), 32'd1);
    chk("busy_windows", 32'(wq.size() - nw), 32'd2);
    w1 = win_at(nw + 1);
    chk("busy_cmd_t2", 32'(w1.cmd), 32'h0800);

    // Asynchronous reset in the middle of the addressing transaction.
    miso_word = {4'h5, 12'h777};
    @(negedge clk); strt_cnv = 1'b1; chnnl = 3'd4;
    @(negedge clk); strt_cnv = 1'b0;
    repeat (300) @(negedge clk);
    chk("mid_ss_low", 32'(SS_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ss_n", 32'(SS_n), 32'd1);
    chk("arst_sclk", 32'(SCLK), 32'd1);
    chk("arst_mosi", 32'(MOSI), 32'd0);
    chk("arst_cmplt", 32'(cnv_cmplt), 32'd0);
    chk("arst_res", 32'(res), 32'h000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c0 = cmplt_cnt; f0 = ss_falls;
    repeat (1200) @(negedge clk);
    chk("arst_no_cmplt", 32'(cmplt_cnt - c0), 32'd0);
    chk("arst_no_window", 32'(ss_falls - f0), 32'd0);

    // Same channel twice in a row.
    nw = wq.size();
    run_conv(3'd2, 12'h2A5, got, lead, lat);
    chk("rep1_res", 32'(got), 32'h2A5);
    chk("rep1_windows", 32'(wq.size() - nw), 32'd2);
    chk("rep1_latency", 32'(lat), 32'(LAT_FULL));
    nw = wq.size();
    run_conv(3'd2, 12'h5A2, got, lead, lat);
    w0 = win_at(nw);
    chk("rep2_res", 32'(got), 32'h5A2);
    chk("rep2_res_lead", 32'(lead), 32'h5A2);
    chk("rep2_windows", 32'(wq.size() - nw), 32'(REP_WIN));
    chk("rep2_latency", 32'(lat), 32'(REP_LAT));
    chk("rep2_cmd", 32'(w0.cmd), 32'h1000);

    chk("cmplt_width", 32'(cmplt_run_max), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
